// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory request in flight and
// buffers one instruction for decode. Redirects drop the stale in-flight response.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned IF_TO_ID_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [31:0]               imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [31:0]               imem_rdata,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  output logic                      if_flush,
  input  logic                      br_redirect,
  input  logic [31:0]               br_target,
  input  logic                      exc_redirect,
  input  logic [31:0]               exc_target
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                      state_q, state_d;
  logic [31:0]                 fetch_pc_q, fetch_pc_d;
  logic [31:0]                 req_pc_q, req_pc_d;
  logic                        discard_q, discard_d;
  logic                        out_valid_q, out_valid_d;
  logic [IF_TO_ID_WIDTH-1:0]   out_bus_q, out_bus_d;
  logic                        flush_pending_q, flush_pending_d;
  logic                        out_flush_q, out_flush_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        resp;

  assign redirect   = exc_redirect | br_redirect;
  assign target_raw = exc_redirect ? exc_target : br_target;
  assign target     = target_raw & ~32'h3;
  assign resp       = (state_q == StWait) & imem_rvalid;

  assign imem_req       = !rst & (state_q == StIdle) & !redirect & (!out_valid_q | id_allowin);
  assign imem_addr      = fetch_pc_q;
  assign if_to_id_valid = out_valid_q;
  assign if_to_id_bus   = out_bus_q;
  assign if_flush       = out_flush_q & out_valid_q;

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    req_pc_d        = req_pc_q;
    discard_d       = discard_q;
    out_valid_d     = out_valid_q;
    out_bus_d       = out_bus_q;
    flush_pending_d = flush_pending_q;
    out_flush_d     = out_flush_q;

    if (out_valid_q && id_allowin) begin
      out_valid_d = 1'b0;
    end

    if (resp) begin
      state_d = StIdle;
      if (discard_q) begin
        discard_d = 1'b0;
      end else if (!redirect) begin
        out_bus_d       = {imem_rdata, req_pc_q};
        out_valid_d     = 1'b1;
        out_flush_d     = flush_pending_q;
        flush_pending_d = 1'b0;
      end
    end

    if (imem_req && imem_gnt) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      state_d    = StWait;
    end

    // Redirect overrides everything above; a pending response is marked stale.
    if (redirect) begin
      fetch_pc_d  = target;
      out_valid_d = 1'b0;
      if ((state_q == StWait) && !imem_rvalid) begin
        discard_d = 1'b1;
      end
      if (exc_redirect) begin
        flush_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      fetch_pc_q      <= RESET_PC;
      req_pc_q        <= '0;
      discard_q       <= 1'b0;
      out_valid_q     <= 1'b0;
      out_bus_q       <= '0;
      flush_pending_q <= 1'b0;
      out_flush_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      req_pc_q        <= req_pc_d;
      discard_q       <= discard_d;
      out_valid_q     <= out_valid_d;
      out_bus_q       <= out_bus_d;
      flush_pending_q <= flush_pending_d;
      out_flush_q     <= out_flush_d;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: a 1-deep memory responder for the main instance and a
// hand-driven second instance with a wrapping reset PC.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst, imem_gnt, id_allowin, br_redirect, exc_redirect;
  logic [31:0] br_target, exc_target;
  logic        imem_req, imem_rvalid, if_to_id_valid, if_flush;
  logic [31:0] imem_addr, imem_rdata;
  logic [63:0] if_to_id_bus;

  logic        rst2, gnt2, rvalid2, allowin2;
  logic [31:0] rdata2;
  logic        req2, valid2, flush2;
  logic [31:0] addr2;
  logic [63:0] bus2;

  // Memory model: the response follows a grant and is held off while hold_resp is set.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        hold_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rvalid = pend & !hold_resp;
  assign imem_rdata  = mem_word(pend_addr);

  always @(posedge clk) begin
    if (imem_rvalid) pend <= 1'b0;
    if (imem_req && imem_gnt) begin
      pend      <= 1'b1;
      pend_addr <= imem_addr;
    end
  end

  ifetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_allowin(id_allowin),
    .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus), .if_flush(if_flush),
    .br_redirect(br_redirect), .br_target(br_target), .exc_redirect(exc_redirect),
    .exc_target(exc_target)
  );

  ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .id_allowin(allowin2),
    .if_to_id_valid(valid2), .if_to_id_bus(bus2), .if_flush(flush2),
    .br_redirect(1'b0), .br_target(32'h0), .exc_redirect(1'b0), .exc_target(32'h0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] pc;
    rst = 1'b1; imem_gnt = 1'b1; id_allowin = 1'b1; hold_resp = 1'b0;
    br_redirect = 1'b0; exc_redirect = 1'b0; br_target = '0; exc_target = '0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (if_to_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_to_id_valid); end
    checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", if_flush); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h8000_0000 + 32'(4 * i);
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== pc) begin
        errors++; $display("FAIL seq_req[%0d] got %b/%h want 1/%h", i, imem_req, imem_addr, pc);
      end
      tick();
      checks++; if (if_to_id_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++; $display("FAIL seq_wait[%0d] got valid %b req %b want 0 0", i, if_to_id_valid, imem_req);
      end
      tick();
      checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {mem_word(pc), pc} || if_flush !== 1'b0) begin
        errors++; $display("FAIL seq_out[%0d] got %b %h %b want 1 %h 0", i, if_to_id_valid, if_to_id_bus, if_flush, {mem_word(pc), pc});
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    held = {mem_word(32'h8000_0008), 32'h8000_0008};
    id_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0 || if_to_id_valid !== 1'b1 || if_to_id_bus !== held) begin
        errors++; $display("FAIL stall[%0d] got req %b valid %b bus %h want 0 1 %h", i, imem_req, if_to_id_valid, if_to_id_bus, held);
      end
      tick();
    end
    id_allowin = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_000C) begin
      errors++; $display("FAIL stall_release got %b/%h want 1/8000000c", imem_req, imem_addr);
    end
    tick();
  endtask

  task automatic test_branch();
    hold_resp = 1'b1;
    #1;
    checks++; if (if_to_id_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL br_wait got valid %b req %b want 0 0", if_to_id_valid, imem_req);
    end
    tick();
    br_redirect = 1'b1; br_target = 32'h8000_0102;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_req_block got %b want 0", imem_req); end
    tick();
    br_redirect = 1'b0;
    hold_resp = 1'b0;  // stale response for 0x8000000c arrives now
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_discard_wait got %b want 0", imem_req); end
    tick();
    checks++; if (if_to_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0100) begin
      errors++; $display("FAIL br_refetch got valid %b req %b addr %h want 0 1 80000100", if_to_id_valid, imem_req, imem_addr);
    end
    tick(); tick();
    checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {mem_word(32'h8000_0100), 32'h8000_0100}) begin
      errors++; $display("FAIL br_deliver got %b %h want 1 pc 80000100", if_to_id_valid, if_to_id_bus);
    end
  endtask

  task automatic test_exc();
    exc_redirect = 1'b1; exc_target = 32'h8000_1000;
    br_redirect = 1'b1; br_target = 32'h8000_0200;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL exc_req_block got %b want 0", imem_req); end
    tick();
    exc_redirect = 1'b0; br_redirect = 1'b0;
    #1;
    checks++; if (if_to_id_valid !== 1'b0 || imem_addr !== 32'h8000_1000 || imem_req !== 1'b1) begin
      errors++; $display("FAIL exc_target got valid %b req %b addr %h want 0 1 80001000", if_to_id_valid, imem_req, imem_addr);
    end
    tick(); tick();
    checks++; if (if_to_id_valid !== 1'b1 || if_flush !== 1'b1 || if_to_id_bus !== {mem_word(32'h8000_1000), 32'h8000_1000}) begin
      errors++; $display("FAIL exc_first got %b %b %h want 1 1 pc 80001000", if_to_id_valid, if_flush, if_to_id_bus);
    end
    tick(); tick();
    checks++; if (if_to_id_valid !== 1'b1 || if_flush !== 1'b0 || if_to_id_bus !== {mem_word(32'h8000_1004), 32'h8000_1004}) begin
      errors++; $display("FAIL exc_second got %b %b %h want 1 0 pc 80001004", if_to_id_valid, if_flush, if_to_id_bus);
    end
  endtask

  task automatic test_redirect_rvalid();
    tick();  // grant for 0x80001008; its response is valid in this cycle
    br_redirect = 1'b1; br_target = 32'h8000_2000;
    tick();
    br_redirect = 1'b0;
    #1;
    checks++; if (if_to_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_2000) begin
      errors++; $display("FAIL rv_redirect got valid %b req %b addr %h want 0 1 80002000", if_to_id_valid, imem_req, imem_addr);
    end
    tick(); tick();
    checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {mem_word(32'h8000_2000), 32'h8000_2000}) begin
      errors++; $display("FAIL rv_deliver got %b %h want 1 pc 80002000", if_to_id_valid, if_to_id_bus);
    end
  endtask

  task automatic test_reset_mid();
    tick();  // grant for 0x80002004
    hold_resp = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    tick();
    imem_gnt = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_to_id_valid !== 1'b0) begin
      errors++; $display("FAIL rst_hold got req %b valid %b want 0 0", imem_req, if_to_id_valid);
    end
    rst = 1'b0;
    hold_resp = 1'b0;  // late response from the pre-reset grant
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL rst_restart got %b/%h want 1/80000000", imem_req, imem_addr);
    end
    tick();
    checks++; if (if_to_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL rst_late_ignored got valid %b req %b addr %h want 0 1 80000000", if_to_id_valid, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    tick(); tick();
    checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {mem_word(32'h8000_0000), 32'h8000_0000}) begin
      errors++; $display("FAIL rst_deliver got %b %h want 1 pc 80000000", if_to_id_valid, if_to_id_bus);
    end
  endtask

  task automatic test_wrap();
    rst2 = 1'b1; gnt2 = 1'b1; rvalid2 = 1'b0; allowin2 = 1'b1; rdata2 = '0;
    tick();
    rst2 = 1'b0;
    #1;
    checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first got %b/%h want 1/fffffffc", req2, addr2);
    end
    tick();
    rvalid2 = 1'b1; rdata2 = 32'h1111_2222;
    tick();
    rvalid2 = 1'b0;
    #1;
    checks++; if (valid2 !== 1'b1 || bus2 !== 64'h1111_2222_FFFF_FFFC || req2 !== 1'b1 || addr2 !== 32'h0) begin
      errors++; $display("FAIL wrap_second got %b %h %b %h want 1 11112222fffffffc 1 00000000", valid2, bus2, req2, addr2);
    end
    tick();
    rvalid2 = 1'b1; rdata2 = 32'h3333_4444;
    tick();
    rvalid2 = 1'b0;
    #1;
    checks++; if (valid2 !== 1'b1 || bus2 !== 64'h3333_4444_0000_0000) begin
      errors++; $display("FAIL wrap_deliver got %b %h want 1 3333444400000000", valid2, bus2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst2 = 1'b1; gnt2 = 1'b0; rvalid2 = 1'b0; allowin2 = 1'b1; rdata2 = '0;
    test_reset();
    test_stall();
    test_branch();
    test_exc();
    test_redirect_rvalid();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch pipeline stage; transmitter side of the IF->ID valid/allowin handshake.
- Owns the fetch PC and issues word requests to the instruction memory port.
- Buffers one returned instruction and presents it to decode as {instruction[31:0], pc[31:0]}.
- Applies redirects from decode (taken branch/jal/jalr) and from the CSR path (ecall/mret/trap), discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- IF_TO_ID_WIDTH, 64, width of if_to_id_bus; fixed at 64.

Ports:
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; equals fetch_pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; in order, at least 1 cycle after its grant.
- imem_rdata  in  32  response instruction.
- id_allowin  in  1  decode can accept this cycle.
- if_to_id_valid  out  1  if_to_id_bus holds a valid instruction.
- if_to_id_bus  out  64  {instruction, pc}.
- if_flush  out  1  qualifies the delivered instruction as the first one after an exception redirect.
- br_redirect  in  1  decode redirect: taken branch/jal/jalr, already qualified by ID valid.
- br_target  in  32  branch target.
- exc_redirect  in  1  trap/mret redirect from CSR/MEM stage.
- exc_target  in  32  mtvec/mepc target.

Behaviour:
- State: FSM IDLE (nothing outstanding) / WAIT (one request granted, response pending).
- Other registers: fetch_pc, req_pc, discard, out_valid, out_bus, flush_pending, out_flush.
- Reset values: fetch_pc=RESET_PC, state=IDLE, discard=0, out_valid=0, out_bus=0, flush_pending=0, out_flush=0. Resulting outputs: imem_req=0 during reset, if_to_id_valid=0, if_flush=0.
- Redirect:
  - redirect = exc_redirect | br_redirect.
  - Exception has priority: target = exc_redirect ? exc_target : br_target.
  - Target is forced to {target[31:2],2'b00}.
- Request issue:
  - imem_req = !rst & state==IDLE & !redirect & (!out_valid | id_allowin).
  - At most one outstanding request.
  - On req&gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, wraps), state<=WAIT.
- Response (state==WAIT & imem_rvalid), state<=IDLE, then one of:
  - discard=1: drop the response, discard<=0.
  - redirect this cycle: drop the response.
  - Otherwise: out_bus<={imem_rdata, req_pc}, out_valid<=1, out_flush<=flush_pending, flush_pending<=0.
- imem_rvalid in IDLE is ignored. This covers a late response from a request granted before reset.
- Handoff:
  - if_to_id_valid = out_valid; if_flush = out_flush & out_valid.
  - Transfer when out_valid & id_allowin: out_valid<=0 unless reloaded in the same cycle.
  - out_bus is held stable while out_valid & !id_allowin.
- Redirect cycle actions (take precedence over request issue, response capture and handoff):
  - fetch_pc<=target; out_valid<=0.
  - If state==WAIT and no imem_rvalid this cycle: discard<=1; state stays WAIT.
  - If exc_redirect: flush_pending<=1.
- Back-to-back redirects while discard=1: discard stays 1. Exactly one stale response is dropped, since only one request can be outstanding.
- Latency: first request in the cycle after reset deasserts. With a 1-cycle memory, instruction valid 1 cycle after grant; sustained rate 1 instruction per 2 cycles.
- Reset mid-operation: all state returns to reset values within the reset cycle; no request is issued while rst=1.

Test Plan:
- Reset sequence: release rst, gnt=1, memory latency 1 -> imem_addr sequence 0x80000000, 0x80000004, 0x80000008; if_to_id_bus={mem[pc],pc} for each; if_flush=0.
- ID stall: id_allowin=0 with out_valid=1 for 5 cycles -> if_to_id_bus stable, imem_req=0; on allowin=1, next request to pc+4 issues that same cycle.
- Branch redirect while WAIT: br_redirect=1, br_target=0x80000102 while response pending -> pending response dropped; next imem_addr=0x80000100; delivered pc=0x80000100.
- Simultaneous exc_redirect (0x80001000) and br_redirect (0x80000200) -> next fetch 0x80001000; first delivered instruction has if_flush=1, second has if_flush=0.
- Redirect coincident with imem_rvalid -> response not delivered; state IDLE; next request to the target in the following cycle.
- Wrap and reset: RESET_PC=0xFFFFFFFC -> second fetch at 0x00000000. Assert rst during WAIT, then deliver late imem_rvalid after reset -> ignored; fetch restarts at RESET_PC.
